ntt_input_loader: RTL and testbench

Streaming front end for the banked coefficient memory. It accepts one 32-bit coefficient per cycle on a valid/ready input and scatters a frame of N×ROWS coefficients across the N banks. Coefficient k goes to bank k mod N, row base_row + k div N. It drives the memory's per-bank write enables, write addresses and write data directly, with one registered stage, and signals frame completion to the NTT controller.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/ntt_input_loader_bank_row_counter.sv | 53 +++++
 rtl/ntt_input_loader.sv | 107 ++++++++++
 tb/tb_ntt_input_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: constants and types shared by the banked coefficient memory and
// the NTT input loader.
//   ADDR_W  - row address width of every memory bank
//   DATA_W  - coefficient width
//   state_t - loader FSM states
package ntt_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/ntt_input_loader_bank_row_counter.sv
// bank_row_counter: tracks where the next accepted coefficient of a frame
// lands. bank counts 0..N-1 and wraps; each wrap advances row 0..ROWS-1.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart at bank 0, row 0 (frame start)
//   advance    - one coefficient accepted
//   bank       - current bank index
//   row        - current row offset within the frame
//   last       - current position is the final coefficient of the frame
module bank_row_counter
    import ntt_pkg::*;
#(
    parameter int N      = 257,
    parameter int ROWS   = 1,
    parameter int BANK_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [BANK_W-1:0] bank,
    output logic [ADDR_W-1:0] row,
    output logic              last
);

    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(N - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(ROWS - 1);

    logic bank_wrap;

    assign bank_wrap = (bank == BANK_LAST);
    assign last      = bank_wrap && (row == ROW_LAST);

    // Compare-and-wrap instead of a modulo; the final beat also returns the
    // row to 0 so the counter is already parked for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
            row  <= '0;
        end else if (clear) begin
            bank <= '0;
            row  <= '0;
        end else if (advance) begin
            if (bank_wrap) begin
                bank <= '0;
                row  <= last ? '0 : row + ADDR_W'(1);
            end else begin
                bank <= bank + BANK_W'(1);
            end
        end
    end

endmodule

// File: rtl/ntt_input_loader.sv
// ntt_input_loader: streams one frame of N*ROWS coefficients from a
// valid/ready input into N memory banks. Coefficient k is written to bank
// k mod N at row base_row + k div N (8-bit wrapping), one registered stage
// after acceptance.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a frame when idle (ignored while loading)
//   base_row    - first row of the frame, sampled with an accepted start
//   s_valid     - input coefficient valid
//   s_data      - input coefficient
//   s_ready     - loader accepts a coefficient this cycle
//   busy        - frame in progress
//   done        - one-cycle pulse alongside the final write strobe
//   we          - per-bank write enable, at most one bit set
//   addr_write  - per-bank write address, lane i at [i*ADDR_W +: ADDR_W]
//   din         - per-bank write data, lane i at [i*DATA_W +: DATA_W]
module ntt_input_loader
    import ntt_pkg::*;
#(
    parameter int N    = 257,
    parameter int ROWS = 1
) (
    input  logic                rst_n,
    input  logic                clk,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_row,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        we,
    output logic [N*ADDR_W-1:0] addr_write,
    output logic [N*DATA_W-1:0] din
);

    localparam int BANK_W = (N > 1) ? $clog2(N) : 1;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [BANK_W-1:0]   bank;
    logic [ADDR_W-1:0]   row;
    logic                last;
    logic                accept;
    logic                clear;

    assign s_ready = (state == LOAD);
    assign busy    = (state == LOAD);
    assign accept  = s_valid && (state == LOAD);
    assign clear   = (state == IDLE) && start;

    bank_row_counter #(
        .N      (N),
        .ROWS   (ROWS),
        .BANK_W (BANK_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (accept),
        .bank    (bank),
        .row     (row),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= accept && last;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        base_q <= base_row;
                    end
                end
                LOAD: begin
                    if (accept && last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the addressed lane updates; the other lanes hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we         <= '0;
            addr_write <= '0;
            din        <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                we[i] <= accept && (bank == BANK_W'(i));
                if (accept && (bank == BANK_W'(i))) begin
                    addr_write[i*ADDR_W +: ADDR_W] <= base_q + row;
                    din[i*DATA_W +: DATA_W]        <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_input_loader.sv
module tb_ntt_input_loader;

    typedef struct {
        int          bank;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- N=5, ROWS=3 instance ----------------
    logic         rst5 = 1'b0;
    logic         start5 = 1'b0;
    logic [7:0]   base5 = '0;
    logic         s_valid5 = 1'b0;
    logic [31:0]  s_data5 = '0;
    logic         s_ready5, busy5, done5;
    logic [4:0]   we5;
    logic [39:0]  addr5;
    logic [159:0] din5;

    ntt_input_loader #(.N(5), .ROWS(3)) dut5 (
        .rst_n      (rst5),
        .clk        (clk),
        .start      (start5),
        .base_row   (base5),
        .s_valid    (s_valid5),
        .s_data     (s_data5),
        .s_ready    (s_ready5),
        .busy       (busy5),
        .done       (done5),
        .we         (we5),
        .addr_write (addr5),
        .din        (din5)
    );

    // ---------------- N=257, ROWS=1 instance ----------------
    logic          rst257 = 1'b0;
    logic          start257 = 1'b0;
    logic [7:0]    base257 = '0;
    logic          s_valid257 = 1'b0;
    logic [31:0]   s_data257 = '0;
    logic          s_ready257, busy257, done257;
    logic [256:0]  we257;
    logic [2055:0] addr257;
    logic [8223:0] din257;

    ntt_input_loader #(.N(257), .ROWS(1)) dut257 (
        .rst_n      (rst257),
        .clk        (clk),
        .start      (start257),
        .base_row   (base257),
        .s_valid    (s_valid257),
        .s_data     (s_data257),
        .s_ready    (s_ready257),
        .busy       (busy257),
        .done       (done257),
        .we         (we257),
        .addr_write (addr257),
        .din        (din257)
    );

    exp_t q5[$];
    exp_t q257[$];
    int   done_cnt5   = 0;
    int   done_cnt257 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] oh;
        if (done5) done_cnt5++;
        if (we5 != '0) begin
            if (q5.size() == 0) begin
                chk("we5_unexpected", {59'd0, we5}, 64'd0);
            end else begin
                e  = q5.pop_front();
                oh = '0;
                oh[e.bank] = 1'b1;
                chk("we5_onehot", {59'd0, we5}, {59'd0, oh});
                chk("addr5_lane", {56'd0, addr5[e.bank*8 +: 8]}, {56'd0, e.addr});
                chk("din5_lane", {32'd0, din5[e.bank*32 +: 32]}, {32'd0, e.data});
                chk("done5_with_write", {63'd0, done5}, {63'd0, e.last});
            end
        end else begin
            chk("done5_without_write", {63'd0, done5}, 64'd0);
        end
    end

    always @(negedge clk) begin
        exp_t         e;
        logic [256:0] oh;
        if (done257) done_cnt257++;
        if (we257 != '0) begin
            if (q257.size() == 0) begin
                chk("we257_unexpected", 64'd1, 64'd0);
            end else begin
                e  = q257.pop_front();
                oh = '0;
                oh[e.bank] = 1'b1;
                chk("we257_onehot", {63'd0, (we257 == oh)}, 64'd1);
                chk("addr257_lane", {56'd0, addr257[e.bank*8 +: 8]}, {56'd0, e.addr});
                chk("din257_lane", {32'd0, din257[e.bank*32 +: 32]}, {32'd0, e.data});
                chk("done257_with_write", {63'd0, done257}, {63'd0, e.last});
            end
        end else begin
            chk("done257_without_write", {63'd0, done257}, 64'd0);
        end
    end

    // ---------------- N=5 frame driver ----------------
    // abort_at >= 0: assert reset right after that beat is accepted.
    task automatic run5(input logic [7:0] base, input bit gaps, input bit mid_start,
                        input bit start_last, input int abort_at, input logic [31:0] dbase);
        int   k, cyc, d0;
        exp_t e;
        d0 = done_cnt5;
        @(posedge clk); #1;
        start5 = 1'b1;
        base5  = base;
        @(posedge clk); #1;
        start5 = 1'b0;
        base5  = ~base;
        chk("ready5_after_start", {63'd0, s_ready5}, 64'd1);
        chk("busy5_after_start", {63'd0, busy5}, 64'd1);
        k = 0;
        cyc = 0;
        while (k < 15) begin
            start5 = 1'b0;
            if (gaps && (cyc % 3 == 2)) begin
                s_valid5 = 1'b0;
                s_data5  = 32'hDEAD0000 + 32'(cyc);
            end else begin
                s_valid5 = 1'b1;
                s_data5  = dbase + 32'(k);
                e.bank = k % 5;
                e.addr = base + 8'(k / 5);
                e.data = dbase + 32'(k);
                e.last = (k == 14);
                q5.push_back(e);
                if (mid_start && k == 4) begin
                    start5 = 1'b1;
                    base5  = base + 8'd50;
                end
                if (start_last && k == 14) start5 = 1'b1;
                k++;
            end
            cyc++;
            @(posedge clk); #1;
            if (k < 15) chk("ready5_in_frame", {63'd0, s_ready5}, 64'd1);
            if (abort_at >= 0 && k == abort_at + 1) begin
                rst5     = 1'b0;
                s_valid5 = 1'b0;
                start5   = 1'b0;
                #1;
                chk("abort_we5", {59'd0, we5}, 64'd0);
                chk("abort_done5", {63'd0, done5}, 64'd0);
                chk("abort_ready5", {63'd0, s_ready5}, 64'd0);
                chk("abort_busy5", {63'd0, busy5}, 64'd0);
                chk("abort_addr5_zero", {63'd0, (addr5 == '0)}, 64'd1);
                chk("abort_din5_zero", {63'd0, (din5 == '0)}, 64'd1);
                q5.delete();
                repeat (2) @(posedge clk);
                #1 rst5 = 1'b1;
                chk("abort_no_done5", 64'(done_cnt5), 64'(d0));
                return;
            end
        end
        chk("final5_busy_low", {63'd0, busy5}, 64'd0);
        chk("final5_ready_low", {63'd0, s_ready5}, 64'd0);
        chk("final5_done_high", {63'd0, done5}, 64'd1);
        s_valid5 = 1'b0;
        start5   = 1'b0;
        @(posedge clk); #1;
        chk("final5_done_drops", {63'd0, done5}, 64'd0);
        chk("start_with_last_ignored", {63'd0, busy5}, 64'd0);
        for (int b = 0; b < 5; b++) begin
            chk("hold5_din", {32'd0, din5[b*32 +: 32]}, {32'd0, dbase + 32'(10 + b)});
            chk("hold5_addr", {56'd0, addr5[b*8 +: 8]}, {56'd0, base + 8'd2});
        end
        chk("done5_count", 64'(done_cnt5), 64'(d0 + 1));
        chk("q5_drained", 64'(q5.size()), 64'd0);
    endtask

    task automatic run257(input logic [7:0] base, input logic [31:0] dbase);
        exp_t e;
        int   d0;
        d0 = done_cnt257;
        @(posedge clk); #1;
        start257 = 1'b1;
        base257  = base;
        @(posedge clk); #1;
        start257 = 1'b0;
        base257  = 8'h00;
        for (int k = 0; k < 257; k++) begin
            s_valid257 = 1'b1;
            s_data257  = dbase + 32'(k);
            e.bank = k;
            e.addr = base;
            e.data = dbase + 32'(k);
            e.last = (k == 256);
            q257.push_back(e);
            @(posedge clk); #1;
        end
        s_valid257 = 1'b0;
        chk("final257_done_high", {63'd0, done257}, 64'd1);
        chk("final257_busy_low", {63'd0, busy257}, 64'd0);
        @(posedge clk); #1;
        chk("final257_done_drops", {63'd0, done257}, 64'd0);
        for (int b = 0; b < 257; b++) begin
            chk("mem257_din", {32'd0, din257[b*32 +: 32]}, {32'd0, dbase + 32'(b)});
            chk("mem257_addr", {56'd0, addr257[b*8 +: 8]}, {56'd0, base});
        end
        chk("done257_count", 64'(done_cnt257), 64'(d0 + 1));
    endtask

    initial begin
        #1;
        chk("rst_we5", {59'd0, we5}, 64'd0);
        chk("rst_busy5", {63'd0, busy5}, 64'd0);
        chk("rst_ready5", {63'd0, s_ready5}, 64'd0);
        chk("rst_done5", {63'd0, done5}, 64'd0);
        chk("rst_din5", {63'd0, (din5 == '0)}, 64'd1);
        chk("rst_addr5", {63'd0, (addr5 == '0)}, 64'd1);
        chk("rst_we257", {63'd0, (we257 == '0)}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst5   = 1'b1;
        rst257 = 1'b1;

        // s_valid while idle: no acceptance, no write
        for (int i = 0; i < 3; i++) begin
            s_valid5 = 1'b1;
            s_data5  = 32'h5555_0000 + 32'(i);
            @(posedge clk); #1;
            chk("idle_ready5", {63'd0, s_ready5}, 64'd0);
            chk("idle_we5", {59'd0, we5}, 64'd0);
        end
        s_valid5 = 1'b0;

        run5(8'd0,   1'b0, 1'b0, 1'b0, -1, 32'd100);    // continuous
        run5(8'd0,   1'b1, 1'b0, 1'b1, -1, 32'd200);    // gaps, start with last beat
        run5(8'd254, 1'b0, 1'b0, 1'b0, -1, 32'd300);    // row wrap 254,255,0
        run5(8'd17,  1'b0, 1'b1, 1'b0, -1, 32'd400);    // start at beat 4 ignored
        run5(8'd40,  1'b0, 1'b0, 1'b0,  7, 32'd500);    // abort after beat 7
        run5(8'd9,   1'b1, 1'b0, 1'b0, -1, 32'd600);    // full frame after abort

        run257(8'd200, 32'hA000_0000);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
